// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ctrl
// Purpose  : Multi-cycle, word-organised, little-endian data memory for the
//            MEM stage. Supports byte/half/word stores and signed/unsigned
//            sub-word loads. A programmable number of wait cycles is inserted
//            before each access commits, and stall_o/done_o hold the pipeline
//            while the access is in flight.
// Ports    : clk_i        clock, rising edge
//            rst_i        asynchronous active-low reset
//            MemRead_i    load request, held until done_o
//            MemWrite_i   store request, held until done_o (wins over load)
//            Size_i       00 byte, 01 half, 1x word
//            Unsigned_i   load zero-extend (1) / sign-extend (0)
//            Addr_i       byte address (aliases modulo 4*DEPTH)
//            WriteData_i  store data, sub-word stores use the low bits
//            ReadData_o   registered load result
//            stall_o      pipeline hold
//            done_o       one-cycle completion pulse
//            err_o        misaligned-access flag, valid with done_o
// Options  : DMEM_ALIGN_CHECK_EN - when defined, misaligned half/word accesses
//            perform no memory access and raise err_o with done_o.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        Size_i,
    input  logic              Unsigned_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [31:0]       WriteData_i,
    output logic [31:0]       ReadData_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int       c_IDX_W = $clog2(DEPTH);
    localparam int       c_LOW_W = c_IDX_W + 2;
    localparam logic [3:0] c_LAT = 4'(LATENCY);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_cnt;

    // Latched request
    logic [c_LOW_W-1:0] r_addr;
    logic [31:0]        r_wdata;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic               r_is_store;

    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic               w_commit;
    logic               w_misalign;

    // Effective access: live inputs in IDLE (needed for zero-latency commit),
    // latched copy otherwise.
    logic [c_LOW_W-1:0] w_c_addr;
    logic [31:0]        w_c_wdata;
    logic [1:0]         w_c_size;
    logic               w_c_unsigned;
    logic               w_c_store;

    logic [c_IDX_W-1:0] w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [31:0]        w_rword;
    logic [31:0]        w_shift;
    logic [15:0]        w_half;
    logic [31:0]        w_load_val;

    assign w_req = MemRead_i | MemWrite_i;

    // Upper address bits only alias; they are intentionally unused.
    generate
        if (ADDR_W > c_LOW_W) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^Addr_i[ADDR_W-1:c_LOW_W];
        end
    endgenerate

    always_comb begin
        if (r_state == c_ST_IDLE) begin
            w_c_addr     = Addr_i[c_LOW_W-1:0];
            w_c_wdata    = WriteData_i;
            w_c_size     = Size_i;
            w_c_unsigned = Unsigned_i;
            w_c_store    = MemWrite_i;
        end else begin
            w_c_addr     = r_addr;
            w_c_wdata    = r_wdata;
            w_c_size     = r_size;
            w_c_unsigned = r_unsigned;
            w_c_store    = r_is_store;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = ((w_c_size == 2'b01) && w_c_addr[0]) ||
                        (w_c_size[1] && (w_c_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Commit on the IDLE edge for zero latency, else on the last WAIT edge.
    assign w_commit = (((r_state == c_ST_IDLE) && w_req && (c_LAT == 4'd0)) ||
                       ((r_state == c_ST_WAIT) && (r_cnt <= 4'd1))) && !w_misalign;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_req) begin
                    w_next_state = (c_LAT == 4'd0) ? c_ST_RESP : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = c_ST_RESP;
                end
            end
            c_ST_RESP: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (r_state)
            c_ST_IDLE: stall_o = w_req;
            c_ST_WAIT: stall_o = 1'b1;
            c_ST_RESP: done_o  = 1'b1;
            default: ;
        endcase
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (r_state == c_ST_IDLE && w_req) begin
            r_err <= w_misalign;
        end
    end

    assign err_o = (r_state == c_ST_RESP) && r_err;
`else
    assign err_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request latch and wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_is_store <= 1'b0;
        end else begin
            if (r_state == c_ST_IDLE && w_req) begin
                r_cnt      <= c_LAT;
                r_addr     <= Addr_i[c_LOW_W-1:0];
                r_wdata    <= WriteData_i;
                r_size     <= Size_i;
                r_unsigned <= Unsigned_i;
                r_is_store <= MemWrite_i;
            end else if (r_state == c_ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane steering
    // ------------------------------------------------------------------
    assign w_idx   = w_c_addr[c_LOW_W-1:2];
    assign w_rword = r_mem[w_idx];
    assign w_shift = w_rword >> {w_c_addr[1:0], 3'b000};
    assign w_half  = w_c_addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = w_c_wdata;
        w_load_val  = w_rword;
        case (w_c_size)
            2'b00: begin
                w_be        = 4'b0001 << w_c_addr[1:0];
                w_wdata_rep = {4{w_c_wdata[7:0]}};
                w_load_val  = {{24{~w_c_unsigned & w_shift[7]}}, w_shift[7:0]};
            end
            2'b01: begin
                w_be        = w_c_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{w_c_wdata[15:0]}};
                w_load_val  = {{16{~w_c_unsigned & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

    // Storage is deliberately not reset. The rst_i gate keeps a held
    // zero-latency request from writing while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (w_commit && w_c_store && rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ReadData_o <= 32'd0;
        end else if (w_commit && !w_c_store) begin
            ReadData_o <= w_load_val;
        end
    end

endmodule
`default_nettype wire
